lsu_axi: RTL and testbench

Memory-access stage between the execute stage (upstream, valid/ready) and write-back (downstream, valid/ready).
- Takes one instruction at a time and, for loads and stores, runs a single-beat AXI4-Lite-style transaction on the core's data master port.
- Aligns store data and strobes, extracts and extends load data, and hands rd/write-enable/result to write-back.
- Non-memory instructions pass straight through.

---
 rtl/lsu_axi_if.sv | 38 +++
 rtl/lsu_axi.sv | 147 ++++++++++++++
 tb/tb_lsu_axi.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_axi_if.sv
// lsu_axi_if: single-beat AXI4-Lite-style data port (AR/R/AW/W/B) between the LSU and memory.
// The master modport is the LSU side and the slave modport is the memory side.
interface lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                ar_valid;
  logic                ar_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic [2:0]          ar_size;
  logic                r_valid;
  logic                r_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                aw_valid;
  logic                aw_ready;
  logic [ADDR_W-1:0]   aw_addr;
  logic [2:0]          aw_size;
  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                b_valid;
  logic                b_ready;
  logic [1:0]          b_resp;

  modport master (
    output ar_valid, ar_addr, ar_size, r_ready,
    output aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, ar_size, r_ready,
    input  aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/lsu_axi.sv
// lsu_axi: memory-access stage; one instruction at a time, single-beat AXI loads/stores, ALU ops pass through.
// Build option LSU_MISALIGN_CHECK_EN: misaligned half/word accesses complete with w_err_o=1 and no bus traffic.
module lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_valid_i,
  output logic              m_ready_o,
  input  logic [31:0]       e_res_i,
  input  logic [DATA_W-1:0] e_wdata_i,
  input  logic              e_wenMem_i,
  input  logic              e_renMem_i,
  input  logic [1:0]        e_mask_i,
  input  logic              e_is_load_signed_i,
  input  logic [4:0]        e_rd_i,
  input  logic              e_wenReg_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [4:0]        w_rd_o,
  output logic              w_wenReg_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_err_o,
  lsu_axi_if.master         mst,
  output logic [2:0]        dbg_state
);
  // Every channel uses valid/ready: a transfer happens on a rising edge where both are high;
  // a raised valid and its payload are held unchanged until that edge.
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

  state_t            state, state_nx;
  logic [31:0]       res_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        mask_q;
  logic              signed_q;
  logic              aw_done, w_done;
  logic              accept, misalign;
  logic [4:0]        sh;
  logic [DATA_W-1:0] raw, load_ext;
  logic [3:0]        strb_base;

  assign accept    = e_valid_i && m_ready_o;
  assign sh        = {res_q[1:0], 3'b000};
  assign dbg_state = state;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (e_renMem_i || e_wenMem_i) &&
                    (((e_mask_i == 2'd1) && e_res_i[0]) ||
                     ((e_mask_i == 2'd2) && (e_res_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    m_ready_o    = (state == IDLE) && rst_i;
    w_valid_o    = (state == DONE);
    mst.ar_valid = (state == RD_A);
    mst.r_ready  = (state == RD_D);
    mst.aw_valid = (state == WR) && !aw_done;
    mst.w_valid  = (state == WR) && !w_done;
    mst.b_ready  = (state == WR_B);
    case (state)
      IDLE: if (accept) begin
        if (misalign)        state_nx = DONE;
        else if (e_renMem_i) state_nx = RD_A;
        else if (e_wenMem_i) state_nx = WR;
        else                 state_nx = DONE;
      end
      RD_A: if (mst.ar_ready) state_nx = RD_D;
      RD_D: if (mst.r_valid)  state_nx = DONE;
      // Address and data may complete in either order or together.
      WR:   if ((aw_done || mst.aw_ready) && (w_done || mst.w_ready)) state_nx = WR_B;
      WR_B: if (mst.b_valid)  state_nx = DONE;
      DONE: if (w_ready_i)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    raw = mst.r_data >> sh;
    case (mask_q)
      2'd0:    load_ext = {{24{signed_q & raw[7]}}, raw[7:0]};
      2'd1:    load_ext = {{16{signed_q & raw[15]}}, raw[15:0]};
      default: load_ext = raw;
    endcase
    case (mask_q)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // Bus payloads are zero outside their phase so idle outputs stay quiet.
  assign mst.ar_addr = (state == RD_A) ? {res_q[ADDR_W-1:2], 2'b00} : '0;
  assign mst.ar_size = (state == RD_A) ? {1'b0, mask_q} : 3'd0;
  assign mst.aw_addr = (state == WR) ? {res_q[ADDR_W-1:2], 2'b00} : '0;
  assign mst.aw_size = (state == WR) ? {1'b0, mask_q} : 3'd0;
  assign mst.w_data  = (state == WR) ? (wdata_q << sh) : '0;
  assign mst.w_strb  = (state == WR) ? (strb_base << res_q[1:0]) : 4'b0000;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      res_q      <= '0;
      wdata_q    <= '0;
      mask_q     <= 2'd0;
      signed_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      w_rd_o     <= 5'd0;
      w_wenReg_o <= 1'b0;
      w_data_o   <= '0;
      w_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          res_q      <= e_res_i;
          wdata_q    <= e_wdata_i;
          mask_q     <= e_mask_i;
          signed_q   <= e_is_load_signed_i;
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
          w_rd_o     <= e_rd_i;
          w_wenReg_o <= e_wenReg_i && !misalign;
          w_data_o   <= e_res_i;
          w_err_o    <= misalign;
        end
        RD_D: if (mst.r_valid) begin
          w_data_o <= load_ext;
          w_err_o  <= (mst.r_resp != 2'b00);
        end
        WR: begin
          if (mst.aw_ready) aw_done <= 1'b1;
          if (mst.w_ready)  w_done  <= 1'b1;
        end
        WR_B: if (mst.b_valid) w_err_o <= (mst.b_resp != 2'b00);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_axi.sv
// tb_lsu_axi: random and directed stimulus for lsu_axi against a byte-level reference model.
// A responding AXI slave with per-channel delays and a write-back scoreboard run alongside the driver.
module tb_lsu_axi;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        e_valid_i, m_ready_o;
  logic [31:0] e_res_i, e_wdata_i;
  logic        e_wenMem_i, e_renMem_i, e_is_load_signed_i, e_wenReg_i;
  logic [1:0]  e_mask_i;
  logic [4:0]  e_rd_i;
  logic        w_valid_o, w_ready_i, w_wenReg_o, w_err_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_data_o;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_axi_if axi ();

  lsu_axi dut (
    .clk_i(clk), .rst_i(rst_i),
    .e_valid_i(e_valid_i), .m_ready_o(m_ready_o),
    .e_res_i(e_res_i), .e_wdata_i(e_wdata_i),
    .e_wenMem_i(e_wenMem_i), .e_renMem_i(e_renMem_i),
    .e_mask_i(e_mask_i), .e_is_load_signed_i(e_is_load_signed_i),
    .e_rd_i(e_rd_i), .e_wenReg_i(e_wenReg_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_rd_o(w_rd_o), .w_wenReg_o(w_wenReg_o),
    .w_data_o(w_data_o), .w_err_o(w_err_o),
    .mst(axi), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte lanes) ----------------
  function automatic int access_bytes(input logic [1:0] mask);
    return (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                           input logic [1:0] mask, input logic sgn);
    logic [31:0] v;
    int n;
    n = access_bytes(mask);
    v = 32'h0;
    for (int b = 0; b < 4; b++)
      if (b < n && off + b < 4) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (sgn && n < 4 && v[8*n-1])
      for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] mask, input int off);
    logic [3:0] s;
    s = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + access_bytes(mask)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int off);
    logic [31:0] v;
    v = 32'h0;
    for (int b = 0; b < 4; b++)
      if (b >= off) v[8*b +: 8] = d[8*(b-off) +: 8];
    return v;
  endfunction

  // ---------------- per-transaction slave settings and expectations ----------------
  logic [31:0] tx_rdata;
  logic [1:0]  tx_rresp, tx_bresp;
  int          d_ar, d_r, d_aw, d_w, d_b;
  logic        exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata;
  logic [2:0]  exp_size;
  logic [3:0]  exp_strb;
  logic        ar_bad, aw_bad;

  logic [38:0] exp_q[$];
  int          done_cnt = 0;
  int          target = 0;
  logic        wr_rand = 1'b0;
  logic        wr_fixed = 1'b1;

  // ---------------- AXI slave ----------------
  logic ar_seen, aw_seen, w_seen, aw_got, w_got, rd_act, b_act;
  int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  task automatic slave_clear();
    axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_data = 32'h0; axi.r_resp = 2'b00;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    rd_act = 1'b0; b_act = 1'b0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_i) slave_clear();
      else begin
        if (axi.ar_ready) begin
          axi.ar_ready = 1'b0; ar_seen = 1'b0; rd_act = 1'b1; r_cnt = d_r;
        end else if (axi.ar_valid) begin
          if (!exp_rd && !ar_bad) begin ar_bad = 1'b1; chk("ar_unexpected", 32'd1, 32'd0); end
          if (!ar_seen) begin ar_seen = 1'b1; ar_cnt = d_ar; end
          if (ar_cnt == 0) begin
            axi.ar_ready = 1'b1;
            chk("ar_addr", axi.ar_addr, exp_addr);
            chk("ar_size", 32'(axi.ar_size), 32'(exp_size));
          end else ar_cnt--;
        end
        if (axi.r_valid) axi.r_valid = 1'b0;
        else if (rd_act) begin
          if (r_cnt == 0) begin
            axi.r_valid = 1'b1; axi.r_data = tx_rdata; axi.r_resp = tx_rresp; rd_act = 1'b0;
          end else r_cnt--;
        end
        if (axi.aw_ready) begin
          axi.aw_ready = 1'b0; aw_seen = 1'b0; aw_got = 1'b1;
        end else if (axi.aw_valid) begin
          if (!exp_wr && !aw_bad) begin aw_bad = 1'b1; chk("aw_unexpected", 32'd1, 32'd0); end
          if (!aw_seen) begin aw_seen = 1'b1; aw_cnt = d_aw; end
          if (aw_cnt == 0) begin
            axi.aw_ready = 1'b1;
            chk("aw_addr", axi.aw_addr, exp_addr);
            chk("aw_size", 32'(axi.aw_size), 32'(exp_size));
          end else aw_cnt--;
        end
        if (axi.w_ready) begin
          axi.w_ready = 1'b0; w_seen = 1'b0; w_got = 1'b1;
        end else if (axi.w_valid) begin
          if (!w_seen) begin w_seen = 1'b1; w_cnt = d_w; end
          if (w_cnt == 0) begin
            axi.w_ready = 1'b1;
            chk("w_data", axi.w_data, exp_wdata);
            chk("w_strb", 32'(axi.w_strb), 32'(exp_strb));
          end else w_cnt--;
        end
        if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_act = 1'b1; b_cnt = d_b; end
        if (axi.b_valid) axi.b_valid = 1'b0;
        else if (b_act) begin
          if (b_cnt == 0) begin axi.b_valid = 1'b1; axi.b_resp = tx_bresp; b_act = 1'b0; end
          else b_cnt--;
        end
      end
    end
  end

  // ---------------- write-back ready and scoreboard monitor ----------------
  initial begin
    w_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w_ready_i = wr_rand ? ($urandom_range(0, 1) == 1) : wr_fixed;
    end
  end

  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (rst_i && w_valid_o && w_ready_i) begin
        if (exp_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wb_data", w_data_o, e[31:0]);
          chk("wb_rd", 32'(w_rd_o), 32'(e[36:32]));
          chk("wb_wen", 32'(w_wenReg_o), 32'(e[37]));
          chk("wb_err", 32'(w_err_o), 32'(e[38]));
        end
        done_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic start_tx(input logic [31:0] res, input logic [31:0] wdata, input logic wen,
                          input logic ren, input logic [1:0] mask, input logic sgn,
                          input logic [4:0] rd, input logic wenreg);
    logic        mis, err, wr;
    logic [31:0] data;
    int          off, n;
    off = int'(res % 4);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((ren || wen) && ((mask == 2'd1 && res % 2 != 0) || (mask == 2'd2 && off != 0))) mis = 1'b1;
`endif
    exp_rd = ren && !mis;
    exp_wr = wen && !ren && !mis;
    exp_addr = res - res % 4;
    exp_size = {1'b0, mask};
    exp_wdata = ref_wdata(wdata, off);
    exp_strb = ref_strb(mask, off);
    ar_bad = 1'b0; aw_bad = 1'b0;
    if (mis)      begin data = res; err = 1'b1; wr = 1'b0; end
    else if (ren) begin data = ref_load(tx_rdata, off, mask, sgn); err = (tx_rresp != 0); wr = wenreg; end
    else if (wen) begin data = res; err = (tx_bresp != 0); wr = wenreg; end
    else          begin data = res; err = 1'b0; wr = wenreg; end
    @(negedge clk);
    e_res_i = res; e_wdata_i = wdata; e_wenMem_i = wen; e_renMem_i = ren;
    e_mask_i = mask; e_is_load_signed_i = sgn; e_rd_i = rd; e_wenReg_i = wenreg;
    e_valid_i = 1'b1;
    n = 0;
    while (!m_ready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    exp_q.push_back({err, wr, rd, data});
    target = done_cnt + 1;
    @(negedge clk);
    e_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Cycles from accept until w_valid_o is seen; start_tx returns one negedge after accept.
  task automatic measure_lat(output int lat);
    lat = 1;
    while (!w_valid_o && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
    d_ar = ar; d_r = r; d_aw = aw; d_w = w; d_b = b;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] held;
    logic [1:0]  m;
    int          kind;
    rst_i = 1'b0; e_valid_i = 1'b0; e_res_i = 32'h0; e_wdata_i = 32'h0;
    e_wenMem_i = 1'b0; e_renMem_i = 1'b0; e_mask_i = 2'd0; e_is_load_signed_i = 1'b0;
    e_rd_i = 5'd0; e_wenReg_i = 1'b0;
    tx_rdata = 32'h0; tx_rresp = 2'b00; tx_bresp = 2'b00;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_size = 3'd0;
    exp_strb = 4'h0; ar_bad = 1'b0; aw_bad = 1'b0;
    set_delays(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_m_ready", 32'(m_ready_o), 32'd0);
    chk("rst_w_valid", 32'(w_valid_o), 32'd0);
    chk("rst_ar_valid", 32'(axi.ar_valid), 32'd0);
    chk("rst_aw_valid", 32'(axi.aw_valid), 32'd0);
    chk("rst_w_data", w_data_o, 32'd0);
    chk("rst_w_err", 32'(w_err_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("post_rst_m_ready", 32'(m_ready_o), 32'd1);

    // ALU pass-through
    wr_fixed = 1'b1;
    start_tx(32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd5, 1'b1);
    measure_lat(lat);
    chk("alu_latency", 32'(lat), 32'd1);
    chk("alu_data", w_data_o, 32'h1234);
    chk("alu_rd", 32'(w_rd_o), 32'd5);
    wait_done();

    // Byte loads, signed then unsigned
    tx_rdata = 32'h80FFFFFF; tx_rresp = 2'b00;
    start_tx(32'h80000003, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 5'd7, 1'b1);
    measure_lat(lat);
    chk("lb_latency", 32'(lat), 32'd3);
    chk("lb_signed", w_data_o, 32'hFFFFFF80);
    wait_done();
    start_tx(32'h80000003, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 5'd7, 1'b1);
    measure_lat(lat);
    chk("lbu_unsigned", w_data_o, 32'h00000080);
    wait_done();

    // Half store: aw delayed 2, then both ready together, then w delayed
    tx_bresp = 2'b00;
    set_delays(0, 0, 2, 0, 0);
    start_tx(32'h80000002, 32'h0000ABCD, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 1'b0);
    wait_done();
    set_delays(0, 0, 0, 0, 0);
    start_tx(32'h80000002, 32'h0000ABCD, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 1'b0);
    measure_lat(lat);
    chk("sh_latency", 32'(lat), 32'd3);
    chk("sh_wb_data", w_data_o, 32'h80000002);
    wait_done();
    set_delays(0, 0, 0, 3, 1);
    start_tx(32'h80000001, 32'h12345678, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
    wait_done();

    // Write-back backpressure after a load
    set_delays(0, 0, 0, 0, 0);
    wr_fixed = 1'b0;
    repeat (2) @(negedge clk);
    tx_rdata = 32'hCAFEF00D;
    start_tx(32'h80000010, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd9, 1'b1);
    measure_lat(lat);
    held = w_data_o;
    chk("bp_data", held, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_w_valid", 32'(w_valid_o), 32'd1);
      chk("bp_w_data", w_data_o, held);
      chk("bp_m_ready", 32'(m_ready_o), 32'd0);
      chk("bp_ar_valid", 32'(axi.ar_valid), 32'd0);
    end
    wr_fixed = 1'b1;
    wait_done();

    // Bus error on a word load; then a misaligned word load
    tx_rresp = 2'b10; tx_rdata = 32'h11223344;
    start_tx(32'h80000020, 32'h0, 1'b0, 1'b1, 2'd2, 1'b1, 5'd3, 1'b1);
    measure_lat(lat);
    chk("rresp_err", 32'(w_err_o), 32'd1);
    wait_done();
    tx_rresp = 2'b00;
    start_tx(32'h80000002, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd4, 1'b1);
    measure_lat(lat);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_err", 32'(w_err_o), 32'd1);
    chk("mis_wen", 32'(w_wenReg_o), 32'd0);
`else
    chk("mis_issued_data", w_data_o, 32'h00001122);
`endif
    wait_done();

    // Reset while waiting for read data
    set_delays(0, 20, 0, 0, 0);
    start_tx(32'h80000030, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd1, 1'b1);
    lat = 0;
    while (!axi.r_ready && lat < 50) begin @(negedge clk); lat++; end
    chk("rst_mid_r_ready_seen", 32'(axi.r_ready), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_r_ready", 32'(axi.r_ready), 32'd0);
    chk("rst_mid_w_valid", 32'(w_valid_o), 32'd0);
    chk("rst_mid_m_ready", 32'(m_ready_o), 32'd0);
    chk("rst_mid_ar_valid", 32'(axi.ar_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_release_m_ready", 32'(m_ready_o), 32'd1);
    set_delays(0, 0, 0, 0, 0);
    tx_rdata = 32'h0BADBEEF;
    start_tx(32'h80000032, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1, 5'd2, 1'b1);
    wait_done();

    // Random traffic with random delays and write-back stalls
    wr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      tx_rdata = $urandom();
      tx_rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tx_bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m = 2'($urandom_range(0, 2));
      kind = $urandom_range(0, 9);
      start_tx(32'h80000000 | 32'($urandom_range(0, 255)), $urandom(),
               (kind >= 5), (kind >= 2 && kind <= 4) || kind == 9, m,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_done();
    end
    wr_rand = 1'b0;
    repeat (4) @(negedge clk);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
